// File: rtl/nes_controller_device_pkg.sv
// Shared definitions for the NES joypad device: button bit indices, shift
// length and the device FSM state encoding.
package nes_controller_device_pkg;

  localparam int NES_BITS = 8;

  localparam int NES_BUTTON_A      = 0;
  localparam int NES_BUTTON_B      = 1;
  localparam int NES_BUTTON_SELECT = 2;
  localparam int NES_BUTTON_START  = 3;
  localparam int NES_BUTTON_UP     = 4;
  localparam int NES_BUTTON_DOWN   = 5;
  localparam int NES_BUTTON_LEFT   = 6;
  localparam int NES_BUTTON_RIGHT  = 7;

  // Count value reached after the last of the eight shifts.
  localparam logic [3:0] NES_COUNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    NES_DEV_IDLE  = 2'd0,
    NES_DEV_LOAD  = 2'd1,
    NES_DEV_SHIFT = 2'd2,
    NES_DEV_DONE  = 2'd3
  } nes_dev_state_e;

  // Places the two turbo enables (bit 0 = A, bit 1 = B) onto their button bits.
  function automatic logic [NES_BITS-1:0] nes_turbo_mask(input logic [1:0] turbo);
    logic [NES_BITS-1:0] mask;
    mask               = '0;
    mask[NES_BUTTON_A] = turbo[0];
    mask[NES_BUTTON_B] = turbo[1];
    return mask;
  endfunction

endpackage

// File: rtl/nes_shift_reg_4021.sv
// 4021-style parallel-in / serial-out register with a saturating shift count.
// Serial input is tied low, so reads past the eighth bit return 0.
module nes_shift_reg_4021
  import nes_controller_device_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [NES_BITS-1:0] i_load_data,
  input  logic                i_shift,
  input  logic                i_clear_count,
  output logic                o_data,
  output logic [3:0]          o_bit_count
);

  logic [NES_BITS-1:0] shreg;

  // Load has priority over shift; the count saturates once all bits are out.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shreg       <= '1;
      o_bit_count <= '0;
    end else begin
      if (i_load) begin
        shreg <= i_load_data;
      end else if (i_shift) begin
        shreg <= {1'b0, shreg[NES_BITS-1:1]};
      end

      if (i_clear_count) begin
        o_bit_count <= '0;
      end else if (i_shift && (o_bit_count != NES_COUNT_FULL)) begin
        o_bit_count <= o_bit_count + 4'd1;
      end
    end
  end

  assign o_data = shreg[0];

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous input pin.
module synchronizer (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/nes_controller_device.sv
// Device-side NES joypad emulation: answers a host's latch/clock pins with the
// active-low serial button stream.
// Optional turbo on A/B is enabled by defining NES_DEVICE_TURBO_EN.
//
// state | meaning
// IDLE  | after reset, waiting for the host to raise latch
// LOAD  | latch high, register reloaded from buttons every cycle
// SHIFT | latch fell, each host clock rise shifts out the next bit
// DONE  | all eight bits sent, further clocks read 0
module nes_controller_device
  import nes_controller_device_pkg::*;
#(
  parameter int TURBO_PERIOD = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NES_BITS-1:0] i_buttons,
  input  logic                i_controller_latch,
  input  logic                i_controller_clock,
`ifdef NES_DEVICE_TURBO_EN
  input  logic [1:0]          i_turbo,
`endif
  output logic                o_controller_data,
  output logic                o_poll_strobe,
  output logic                o_done_strobe,
  output logic [3:0]          o_bit_count
);

  if (TURBO_PERIOD < 1) begin : g_turbo_period_check
    $error("TURBO_PERIOD must be at least 1");
  end

  nes_dev_state_e state, state_next;

  logic latch_sync, latch_prev;
  logic clock_sync, clock_prev;
  logic latch_rise, latch_fall, clock_rise;
  logic load, shift, clear_count;
  logic [NES_BITS-1:0] load_data;

  synchronizer u_sync_latch (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_controller_latch),
    .o_q     (latch_sync)
  );

  synchronizer u_sync_clock (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_controller_clock),
    .o_q     (clock_sync)
  );

  // Previous synced pin values for edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      latch_prev <= 1'b0;
      clock_prev <= 1'b0;
    end else begin
      latch_prev <= latch_sync;
      clock_prev <= clock_sync;
    end
  end

  assign latch_rise = latch_sync & ~latch_prev;
  assign latch_fall = ~latch_sync & latch_prev;
  assign clock_rise = clock_sync & ~clock_prev;

`ifdef NES_DEVICE_TURBO_EN
  localparam int CNT_W = $clog2(TURBO_PERIOD + 1);

  logic [CNT_W-1:0] poll_cnt;
  logic             turbo_phase;

  // Poll counter wraps every TURBO_PERIOD polls and flips the turbo phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      poll_cnt    <= '0;
      turbo_phase <= 1'b0;
    end else if (o_poll_strobe) begin
      if (poll_cnt == CNT_W'(TURBO_PERIOD - 1)) begin
        poll_cnt    <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end

  // During the off phase, turbo-enabled buttons load as released.
  assign load_data = turbo_phase ? ~(i_buttons & ~nes_turbo_mask(i_turbo)) : ~i_buttons;
`else
  assign load_data = ~i_buttons;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= NES_DEV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a latch rise always wins over a coincident clock rise.
  always_comb begin
    state_next = state;
    unique case (state)
      NES_DEV_IDLE: begin
        if (latch_sync) state_next = NES_DEV_LOAD;
      end
      NES_DEV_LOAD: begin
        if (latch_fall) state_next = NES_DEV_SHIFT;
      end
      NES_DEV_SHIFT: begin
        if (latch_rise) begin
          state_next = NES_DEV_LOAD;
        end else if (clock_rise && (o_bit_count == NES_COUNT_FULL - 4'd1)) begin
          state_next = NES_DEV_DONE;
        end
      end
      NES_DEV_DONE: begin
        if (latch_rise) state_next = NES_DEV_LOAD;
      end
      default: state_next = NES_DEV_IDLE;
    endcase
  end

  // Output decode: register controls and the two strobes.
  always_comb begin
    load          = 1'b0;
    shift         = 1'b0;
    clear_count   = 1'b0;
    o_poll_strobe = 1'b0;
    o_done_strobe = 1'b0;
    unique case (state)
      NES_DEV_LOAD: begin
        // On the fall cycle the register keeps the last sample taken.
        load          = ~latch_fall;
        clear_count   = latch_fall;
        o_poll_strobe = latch_fall;
      end
      NES_DEV_SHIFT: begin
        shift         = clock_rise & ~latch_rise;
        o_done_strobe = clock_rise & ~latch_rise & (o_bit_count == NES_COUNT_FULL - 4'd1);
      end
      NES_DEV_DONE: begin
        shift = clock_rise & ~latch_rise;
      end
      default: ;
    endcase
  end

  nes_shift_reg_4021 u_shreg (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_load        (load),
    .i_load_data   (load_data),
    .i_shift       (shift),
    .i_clear_count (clear_count),
    .o_data        (o_controller_data),
    .o_bit_count   (o_bit_count)
  );

endmodule

// File: tb/tb_nes_controller_device.sv
// Bench for nes_controller_device: drives the host latch/clock pins with NES
// timing and checks the serial stream against a queue of expected bits.
module tb_nes_controller_device;

  localparam int TP = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       latch = 1'b0;
  logic       cclk = 1'b0;
`ifdef NES_DEVICE_TURBO_EN
  logic [1:0] turbo = 2'b00;
`endif

  logic       data;
  logic       poll;
  logic       done;
  logic [3:0] cnt;

  nes_controller_device #(.TURBO_PERIOD(TP)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_buttons          (buttons),
    .i_controller_latch (latch),
    .i_controller_clock (cclk),
`ifdef NES_DEVICE_TURBO_EN
    .i_turbo            (turbo),
`endif
    .o_controller_data  (data),
    .o_poll_strobe      (poll),
    .o_done_strobe      (done),
    .o_bit_count        (cnt)
  );

  always #20 i_clk = ~i_clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   poll_n = 0;
  int   done_n = 0;
  int   exp_poll = 0;
  int   exp_done = 0;
  logic exp_q[$];

  always @(negedge i_clk) begin
    if (poll === 1'b1) poll_n++;
    if (done === 1'b1) done_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_read(input logic [7:0] btn, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back((i < 8) ? ~btn[i] : 1'b0);
  endtask

  task automatic host_latch();
    latch = 1'b1;
    #12000;
    latch = 1'b0;
    exp_poll++;
    #3000;
  endtask

  task automatic host_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check($sformatf("bit%0d", i), data, exp_q.pop_front());
      cclk = 1'b1;
      #3000;
      cclk = 1'b0;
      #3000;
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge i_clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with pins toggling.
    i_rst_n = 1'b0;
    repeat (4) begin
      @(posedge i_clk);
      latch = ~latch;
      cclk  = ~cclk;
    end
    @(negedge i_clk);
    check("rst_data", data, 1'b1);
    check("rst_count", cnt, 4'd0);
    check("rst_strobes", poll_n + done_n, 0);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    check("post_rst_data", data, 1'b1);

    // Full read; buttons changed after the latch fall must be ignored.
    push_read(8'b1001_0001, 8);
    buttons = 8'b1001_0001;
    host_latch();
    buttons = 8'h3C;
    host_pulses(8);
    exp_done++;
    settle();
    check("full_count", cnt, 4'd8);
    check("full_poll", poll_n, exp_poll);
    check("full_done", done_n, exp_done);
    check("full_tail", data, 1'b0);

    // Over-read returns 0, count saturates, no more strobes.
    push_read(8'h00, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    host_pulses(4);
    settle();
    check("over_count", cnt, 4'd8);
    check("over_done", done_n, exp_done);
    check("over_poll", poll_n, exp_poll);

    // Abort after three shifts, then reload with new buttons.
    buttons = 8'hA5;
    push_read(8'hA5, 3);
    host_latch();
    host_pulses(3);
    settle();
    check("part_count", cnt, 4'd3);
    buttons = 8'h02;
    push_read(8'h02, 8);
    host_latch();
    check("abort_count", cnt, 4'd0);
    check("abort_done", done_n, exp_done);
    host_pulses(8);
    exp_done++;
    settle();
    check("reread_done", done_n, exp_done);
    check("reread_poll", poll_n, exp_poll);
    check("reread_count", cnt, 4'd8);

    // Output follows buttons while latch is held high.
    buttons = 8'h00;
    latch = 1'b1;
    repeat (10) @(negedge i_clk);
    check("track_rel", data, 1'b1);
    buttons = 8'h01;
    repeat (3) @(negedge i_clk);
    check("track_prs", data, 1'b0);
    latch = 1'b0;
    exp_poll++;
    settle();
    check("track_poll", poll_n, exp_poll);

    // Reset in the middle of a transfer: no strobes, outputs to idle values.
    buttons = 8'hC3;
    push_read(8'hC3, 3);
    host_latch();
    host_pulses(3);
    i_rst_n = 1'b0;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    check("midrst_data", data, 1'b1);
    check("midrst_count", cnt, 4'd0);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    check("midrst_done", done_n, exp_done);
    check("midrst_poll", poll_n, exp_poll);

`ifdef NES_DEVICE_TURBO_EN
    // Turbo on A with A held: phase flips every TP polls, counting from reset.
    buttons = 8'h01;
    turbo   = 2'b01;
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back(((p / TP) % 2) == 1);
      host_latch();
      host_pulses(1);
    end
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
